usb_ep_in_arbiter: RTL and testbench
====================================

// Module: usb_ep_in_arbiter
// PURPOSE
//   Round-robin arbiter sharing one USB IN-endpoint data interface between N_REQ local bridges.
//   Sits between the bridges and the usbPeIn data port. Owns the req/grant handshake.
//   Muxes the granted bridge's put/data/done onto the endpoint and steers dataFree back to the owner only.
//   Revokes a grant held idle too long while other bridges wait.
// PARAMETERS
//   N_REQ     4   number of requesters, 2..8
//   IDLE_MAX  16  granted cycles with no put before revocation if others wait; 0 disables revocation
// PORTS
//   i_clk            in   1        clock
//   i_rstn           in   1        asynchronous active-low reset
//   i_req            in   N_REQ    per-bridge request for the IN data interface
//   o_grant          out  N_REQ    one-hot (or zero) registered grant
//   o_grantIdx       out  clog2(N_REQ)  index of owner; 0 when idle
//   o_busy           out  1        any grant active
//   i_dataPut        in   N_REQ    per-bridge byte strobe
//   i_data           in   8*N_REQ  per-bridge byte, bridge k at [8k+7:8k]
//   i_dataDone       in   N_REQ    per-bridge done-with-buffer strobe
//   o_dataFree       out  N_REQ    i_inEp_dataFree gated to owner; 0 for non-owners
//   o_inEp_req       out  1        request toward usbPeIn (== o_busy)
//   i_inEp_grant     in   1        grant from usbPeIn
//   i_inEp_dataFree  in   1        endpoint buffer has space
//   o_inEp_dataPut   out  1        owner put AND i_inEp_grant AND i_inEp_dataFree
//   o_inEp_data      out  8        owner byte (combinational mux)
//   o_inEp_dataDone  out  1        owner done AND i_inEp_grant
//   o_revoked        out  1        one-cycle pulse: grant revoked by idle timeout
// BEHAVIOUR
//   Reset: o_grant=0, o_busy=0, o_inEp_req=0, o_revoked=0, RR pointer=0, idle counter=0.
//   FSM: IDLE (no grant) / OWNED (one grant). Grant is a flop; 1-cycle latency req->grant.
//   IDLE: if any i_req, grant first requester at or after pointer (wrapping) -> OWNED.
//   OWNED, owner k: keep while i_req[k]=1 and not revoked.
//     i_req[k]=0 -> drop grant next cycle; pointer=k+1 mod N_REQ. In that same evaluation
//     pick next requester from k+1 (handover, no idle cycle); none -> IDLE.
//   Idle counter: clears on grant change or owner put; else +1 per OWNED cycle, saturating at IDLE_MAX.
//   Revoke: counter==IDLE_MAX, IDLE_MAX!=0, another i_req pending -> grant moves to next requester
//     after k; o_revoked pulses that cycle; revoked owner must drop and re-request.
//   Counter saturates with no other requester; no revocation, no wrap.
//   Owner put when i_inEp_dataFree=0 or i_inEp_grant=0: not forwarded, counter not cleared.
//   Non-owner put/done/data ignored; never reach endpoint.
//   Grant changes take effect on the flop edge; muxed outputs follow o_grant combinationally.
//   Pointer arithmetic modulo N_REQ; o_grant never has >1 bit set (assertion).
//   i_rstn low mid-transfer: all outputs to reset values immediately, no dataDone emitted.
// TESTING
//   Reset then i_req=4'b0100 at cycle 0 -> o_grant=4'b0100 cycle 1, o_grantIdx=2, o_inEp_req=1.
//   Owner 2 holds, i_req=4'b1111; owner 2 drops -> next cycle o_grant=4'b1000, no idle gap.
//   Owner 0 requests, no puts 16 cycles, bridge 1 requests -> cycle 17 o_grant=4'b0010, o_revoked=1 once.
//   Owner 3 puts 0xA5 while i_inEp_dataFree=0 -> o_inEp_dataPut=0; dataFree=1 -> put=1, data=0xA5.
//   Bridge 1 (non-owner) drives put=1,data=0x3C,done=1 -> o_inEp_dataPut=0, o_inEp_dataDone=0.
//   i_rstn low while granted and putting -> o_grant=0, o_inEp_req=0 immediately; release -> regrant at pointer 0.

Source files
------------

// File: rtl/usb_ep_in_arbiter.sv
// usb_ep_in_arbiter: round-robin owner of one shared USB IN-endpoint data port.
// A single registered grant muxes the owner's strobes through and steers dataFree back to it.
module usb_ep_in_arbiter #(
  parameter int N_REQ    = 4,
  parameter int IDLE_MAX = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rstn,
  input  logic [N_REQ-1:0]         i_req,
  output logic [N_REQ-1:0]         o_grant,
  output logic [$clog2(N_REQ)-1:0] o_grantIdx,
  output logic                     o_busy,
  input  logic [N_REQ-1:0]         i_dataPut,
  input  logic [8*N_REQ-1:0]       i_data,
  input  logic [N_REQ-1:0]         i_dataDone,
  output logic [N_REQ-1:0]         o_dataFree,
  output logic                     o_inEp_req,
  input  logic                     i_inEp_grant,
  input  logic                     i_inEp_dataFree,
  output logic                     o_inEp_dataPut,
  output logic [7:0]               o_inEp_data,
  output logic                     o_inEp_dataDone,
  output logic                     o_revoked
);

  localparam int IDX_W = $clog2(N_REQ);
  localparam int CNT_W = (IDLE_MAX > 0) ? $clog2(IDLE_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(IDLE_MAX);

  typedef enum logic {IDLE, OWNED} stateT;

  stateT            stateQ, stateD;
  logic [N_REQ-1:0] grantQ, grantD;
  logic [N_REQ-1:0] blockQ, blockD;
  logic [N_REQ-1:0] eligible, others;
  logic [IDX_W-1:0] ownerQ, ownerD, ptrQ, ptrD;
  logic [IDX_W-1:0] afterOwner, pickIdle, pickNext;
  logic [CNT_W-1:0] cntQ, cntD;
  logic             revokedD, busy, fwdPut;

  // First set bit of v at or after start, wrapping modulo N_REQ.
  function automatic logic [IDX_W-1:0] rrPick(input logic [N_REQ-1:0] v,
                                               input logic [IDX_W-1:0] start);
    logic [IDX_W-1:0] r;
    logic [IDX_W:0]   sum;
    r = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      sum = {1'b0, start} + (IDX_W+1)'(i);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
      if (v[sum[IDX_W-1:0]]) r = sum[IDX_W-1:0];
    end
    return r;
  endfunction

  assign busy       = |grantQ;
  assign afterOwner = (ownerQ == IDX_W'(N_REQ - 1)) ? '0 : ownerQ + IDX_W'(1);
  // A revoked owner stays masked until it lowers its request once.
  assign eligible   = i_req & ~blockQ;
  assign others     = eligible & ~grantQ;
  assign pickIdle   = rrPick(eligible, ptrQ);
  assign pickNext   = rrPick(others, afterOwner);

  assign o_grant         = grantQ;
  assign o_grantIdx      = ownerQ;
  assign o_busy          = busy;
  assign o_inEp_req      = busy;
  assign o_dataFree      = grantQ & {N_REQ{i_inEp_dataFree}};
  assign fwdPut          = busy & i_dataPut[ownerQ] & i_inEp_grant & i_inEp_dataFree;
  assign o_inEp_dataPut  = fwdPut;
  assign o_inEp_data     = busy ? i_data[{ownerQ, 3'b000} +: 8] : 8'h00;
  assign o_inEp_dataDone = busy & i_dataDone[ownerQ] & i_inEp_grant;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    stateD   = stateQ;
    grantD   = grantQ;
    ownerD   = ownerQ;
    ptrD     = ptrQ;
    cntD     = cntQ;
    blockD   = blockQ & i_req;
    revokedD = 1'b0;
    case (stateQ)
      IDLE: begin
        if (|eligible) begin
          stateD = OWNED;
          ownerD = pickIdle;
          grantD = N_REQ'(1) << pickIdle;
          cntD   = '0;
        end
      end
      OWNED: begin
        if (!i_req[ownerQ]) begin
          ptrD = afterOwner;
          cntD = '0;
          if (|others) begin
            ownerD = pickNext;
            grantD = N_REQ'(1) << pickNext;
          end else begin
            stateD = IDLE;
            ownerD = '0;
            grantD = '0;
          end
        end else if (IDLE_MAX != 0 && cntQ == CNT_MAX && |others) begin
          revokedD       = 1'b1;
          blockD[ownerQ] = 1'b1;
          ptrD           = afterOwner;
          ownerD         = pickNext;
          grantD         = N_REQ'(1) << pickNext;
          cntD           = '0;
        end else if (fwdPut) begin
          cntD = '0;
        end else if (cntQ != CNT_MAX) begin
          cntD = cntQ + CNT_W'(1);
        end
      end
      default: stateD = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      stateQ    <= IDLE;
      grantQ    <= '0;
      ownerQ    <= '0;
      ptrQ      <= '0;
      cntQ      <= '0;
      blockQ    <= '0;
      o_revoked <= 1'b0;
    end else begin
      stateQ    <= stateD;
      grantQ    <= grantD;
      ownerQ    <= ownerD;
      ptrQ      <= ptrD;
      cntQ      <= cntD;
      blockQ    <= blockD;
      o_revoked <= revokedD;
    end
  end

  grantOneHot: assert property (@(posedge i_clk) disable iff (!i_rstn) $onehot0(o_grant));

endmodule

// File: tb/tb_usb_ep_in_arbiter.sv
// Directed bench for usb_ep_in_arbiter: expected values are queued when stimulus
// is applied and popped when the DUT outputs are sampled one time unit after an edge.
module tb_usb_ep_in_arbiter;

  localparam int N_REQ    = 4;
  localparam int IDLE_MAX = 16;

  logic               i_clk = 1'b0;
  logic               i_rstn;
  logic [N_REQ-1:0]   i_req;
  logic [N_REQ-1:0]   o_grant;
  logic [1:0]         o_grantIdx;
  logic               o_busy;
  logic [N_REQ-1:0]   i_dataPut;
  logic [8*N_REQ-1:0] i_data;
  logic [N_REQ-1:0]   i_dataDone;
  logic [N_REQ-1:0]   o_dataFree;
  logic               o_inEp_req;
  logic               i_inEp_grant;
  logic               i_inEp_dataFree;
  logic               o_inEp_dataPut;
  logic [7:0]         o_inEp_data;
  logic               o_inEp_dataDone;
  logic               o_revoked;

  int nTests = 0;
  int nFail  = 0;
  logic [31:0] sbQ[$];

  usb_ep_in_arbiter #(.N_REQ(N_REQ), .IDLE_MAX(IDLE_MAX)) dut (
    .i_clk(i_clk), .i_rstn(i_rstn), .i_req(i_req), .o_grant(o_grant),
    .o_grantIdx(o_grantIdx), .o_busy(o_busy), .i_dataPut(i_dataPut), .i_data(i_data),
    .i_dataDone(i_dataDone), .o_dataFree(o_dataFree), .o_inEp_req(o_inEp_req),
    .i_inEp_grant(i_inEp_grant), .i_inEp_dataFree(i_inEp_dataFree),
    .o_inEp_dataPut(o_inEp_dataPut), .o_inEp_data(o_inEp_data),
    .o_inEp_dataDone(o_inEp_dataDone), .o_revoked(o_revoked)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [31:0] v);
    sbQ.push_back(v);
  endtask

  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    nTests++;
    if (sbQ.size() == 0) begin
      nFail++;
      $display("FAIL %s: observed %0h but scoreboard empty", tag, obs);
    end else begin
      exp = sbQ.pop_front();
      assert (obs === exp) else begin
        nFail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    int  revSeen;
    bit  found;

    i_rstn = 1'b0; i_req = '0; i_dataPut = '0; i_data = '0; i_dataDone = '0;
    i_inEp_grant = 1'b1; i_inEp_dataFree = 1'b1;
    tick(); tick();

    push(0); check("reset_grant", o_grant);
    push(0); check("reset_busy", o_busy);
    push(0); check("reset_inEpReq", o_inEp_req);
    push(0); check("reset_revoked", o_revoked);

    i_rstn = 1'b1;
    tick();
    // Single request: one-cycle latency to grant
    i_req = 4'b0100;
    push(0); #1 check("latency_grant0", o_grant);
    tick();
    push(4'b0100); check("first_grant", o_grant);
    push(2);       check("first_idx", o_grantIdx);
    push(1);       check("first_inEpReq", o_inEp_req);

    // Handover with no idle gap
    i_req = 4'b1111;
    tick();
    push(4'b0100); check("hold_grant", o_grant);
    i_req = 4'b1011;
    tick();
    push(4'b1000); check("handover_grant", o_grant);
    push(3);       check("handover_idx", o_grantIdx);
    push(1);       check("handover_busy", o_busy);

    // Owner put gated by endpoint dataFree
    i_dataPut = 4'b1000; i_data[8*3 +: 8] = 8'hA5; i_inEp_dataFree = 1'b0;
    #1;
    push(0);       check("put_blocked", o_inEp_dataPut);
    push(4'b0000); check("dataFree_blocked", o_dataFree);
    i_inEp_dataFree = 1'b1;
    #1;
    push(1);       check("put_fwd", o_inEp_dataPut);
    push(8'hA5);   check("put_data", o_inEp_data);
    push(4'b1000); check("dataFree_owner", o_dataFree);

    // Non-owner strobes never reach the endpoint
    i_dataPut = 4'b0010; i_dataDone = 4'b0010; i_data = '0; i_data[8*1 +: 8] = 8'h3C;
    #1;
    push(0);     check("nonowner_put", o_inEp_dataPut);
    push(0);     check("nonowner_done", o_inEp_dataDone);
    push(8'h00); check("nonowner_data", o_inEp_data);

    // Owner done qualified by endpoint grant
    i_dataPut = '0; i_dataDone = 4'b1000; i_inEp_grant = 1'b0;
    #1;
    push(0); check("done_nogrant", o_inEp_dataDone);
    i_inEp_grant = 1'b1;
    #1;
    push(1); check("done_fwd", o_inEp_dataDone);

    // Asynchronous reset mid-transfer
    i_dataPut = 4'b1000;
    tick();
    i_rstn = 1'b0;
    #1;
    push(0); check("rst_grant", o_grant);
    push(0); check("rst_inEpReq", o_inEp_req);
    push(0); check("rst_put", o_inEp_dataPut);
    push(0); check("rst_done", o_inEp_dataDone);
    i_dataPut = '0; i_dataDone = '0; i_data = '0; i_req = 4'b1111;
    tick();
    i_rstn = 1'b1;
    tick();
    push(4'b0001); check("regrant_ptr0", o_grant);

    // Idle revocation: owner 0 silent, bridge 1 waiting
    i_req = 4'b0011;
    repeat (IDLE_MAX - 1) tick();
    push(4'b0001); check("idle_hold", o_grant);
    push(0);       check("idle_norevoke", o_revoked);
    found = 1'b0;
    for (int i = 0; i < 4 && !found; i++) begin
      tick();
      if (o_revoked) found = 1'b1;
    end
    push(1);       check("revoke_seen", found);
    push(4'b0010); check("revoke_grant", o_grant);
    tick();
    push(0);       check("revoke_pulse", o_revoked);

    // Revoked bridge 0 must drop before it is eligible again
    i_req = 4'b0001;
    tick();
    push(4'b0000); check("blocked_idle", o_grant);
    i_req = 4'b0000;
    tick();
    i_req = 4'b0001;
    tick();
    push(4'b0001); check("rerequest_grant", o_grant);

    // Saturation with no competitor: no revocation, no wrap
    revSeen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_revoked) revSeen++;
    end
    push(0);       check("sat_norevoke", revSeen);
    push(4'b0001); check("sat_hold", o_grant);
    i_req = 4'b0101;
    tick();
    push(4'b0100); check("sat_revoke_grant", o_grant);
    push(1);       check("sat_revoke_pulse", o_revoked);

    // Forwarded put clears the counter; blocked puts do not
    i_req = 4'b0100;
    repeat (20) tick();
    i_dataPut = 4'b0100;
    #1;
    push(1); check("clear_put_fwd", o_inEp_dataPut);
    tick();
    i_dataPut = '0; i_req = 4'b0101;
    tick();
    push(4'b0100); check("clear_hold", o_grant);
    push(0);       check("clear_norevoke", o_revoked);
    i_dataPut = 4'b0100; i_inEp_dataFree = 1'b0;
    #1;
    push(0); check("blocked_put", o_inEp_dataPut);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      tick();
      if (o_revoked) found = 1'b1;
    end
    push(1);       check("blocked_revoke_seen", found);
    push(4'b0001); check("blocked_revoke_grant", o_grant);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
